// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the dice-to-15 game:
//                choice-stage result codes, game status, controller states
//                and the die range helper.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Result returned by the choice stage with its completion pulse
    typedef enum logic [1:0] {
        RES_CONTINUE = 2'd0,
        RES_LOST     = 2'd1,
        RES_WON      = 2'd2
    } result_t;

    // Externally visible game status
    typedef enum logic [1:0] {
        GS_PLAYING = 2'd0,
        GS_LOST    = 2'd1,
        GS_WON     = 2'd2
    } game_state_t;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WON   = 3'd4,
        ST_LOST  = 3'd5
    } ctrl_state_t;

    localparam logic [3:0] TARGET_SCORE = 4'd15;
    localparam logic [2:0] DIE_MIN      = 3'd1;
    localparam logic [2:0] DIE_MAX      = 3'd6;

    // Next face of the die; any out-of-range value recovers to the lowest face
    function automatic logic [2:0] die_next(input logic [2:0] v);
        if ((v >= DIE_MAX) || (v < DIE_MIN)) begin
            return DIE_MIN;
        end
        return v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dice_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dice_counter
//  Description : Free-running 1..6 die counter; advances one face per
//                enabled cycle and wraps 6 -> 1. Holds when not enabled.
//  Revision    : 1.0  initial release
// ============================================================================
module dice_counter
    import game_pkg::*;
#(
    parameter int DICE_START = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [2:0] value
);

    localparam logic [2:0] C_START = 3'(DICE_START);

    logic [2:0] r_value;

    // Die face register: advance while enabled, otherwise frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= C_START;
        end else if (en) begin
            r_value <= die_next(r_value);
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/dice_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dice_game_ctrl
//  Description : Top-level sequencer for the dice-to-15 game. Spins the die
//                while roll is held, hands the stopped value to the choice
//                stage, then commits the returned score / round / outcome.
//                Optional macro TWO_PLAYER_EN adds a second score register
//                and alternates the active player after each CONTINUE.
//  Revision    : 1.0  initial release
// ============================================================================
module dice_game_ctrl
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS = 15,
    parameter int DICE_START = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    input  logic       choose_done,
    input  logic [1:0] choose_result,
    input  logic [3:0] choose_score,
    output logic       choose_pulse,
    output logic [2:0] roll_num,
    output logic [3:0] score,
    output logic       player,
    output logic [3:0] rounds,
    output logic [1:0] game_state
);

    localparam logic [4:0] C_MAX_ROUNDS = 5'(MAX_ROUNDS);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    logic        r_roll_q;
    logic        w_rise;
    logic        w_fall;
    logic        w_die_en;
    logic [3:0]  r_rounds;
    logic        w_last_round;
    result_t     w_result;
    game_state_t w_game_state;
    logic        w_commit_cont;
    logic        w_commit_won;
    logic        w_commit_lost;
    logic        w_clear;

    assign w_rise       = roll & ~r_roll_q;
    assign w_fall       = ~roll & r_roll_q;
    assign w_result     = result_t'(choose_result);
    assign w_last_round = ({1'b0, r_rounds} + 5'd1) == C_MAX_ROUNDS;

    // The fall cycle is the final value: the die does not step on it
    assign w_die_en = (r_state == ST_SPIN) && !w_fall;

    dice_counter #(
        .DICE_START (DICE_START)
    ) u_dice_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_die_en),
        .value (roll_num)
    );

    // Roll level history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_roll_q <= 1'b0;
        end else begin
            r_roll_q <= roll;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and commit strobes for the data registers
    always_comb begin
        w_state_nxt   = r_state;
        w_commit_cont = 1'b0;
        w_commit_won  = 1'b0;
        w_commit_lost = 1'b0;
        w_clear       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (w_fall) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (choose_done) begin
                    case (w_result)
                        RES_WON: begin
                            w_commit_won = 1'b1;
                            w_state_nxt  = ST_WON;
                        end
                        RES_LOST: begin
                            w_commit_lost = 1'b1;
                            w_state_nxt   = ST_LOST;
                        end
                        // CONTINUE and the unused code 3 both commit the score
                        default: begin
                            w_commit_cont = 1'b1;
                            w_state_nxt   = w_last_round ? ST_LOST : ST_IDLE;
                        end
                    endcase
                end
            end
            ST_WON, ST_LOST: begin
                if (w_rise) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_SPIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Round counter: cleared on a new game, bumped on each committed CONTINUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rounds <= 4'd0;
        end else if (w_clear) begin
            r_rounds <= 4'd0;
        end else if (w_commit_cont) begin
            r_rounds <= r_rounds + 4'd1;
        end
    end

`ifdef TWO_PLAYER_EN
    logic [1:0][3:0] r_score;
    logic            r_player;

    // Per-player scores; the active player alternates after each CONTINUE
    // that does not end the game, and is held on a win or loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score  <= '0;
            r_player <= 1'b0;
        end else if (w_clear) begin
            r_score  <= '0;
            r_player <= 1'b0;
        end else if (w_commit_cont) begin
            r_score[r_player] <= choose_score;
            if (!w_last_round) begin
                r_player <= ~r_player;
            end
        end else if (w_commit_won) begin
            r_score[r_player] <= TARGET_SCORE;
        end else if (w_commit_lost) begin
            r_score[r_player] <= 4'd0;
        end
    end

    assign score  = r_score[r_player];
    assign player = r_player;
`else
    logic [3:0] r_score;

    // Single score register for the only player
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= 4'd0;
        end else if (w_clear) begin
            r_score <= 4'd0;
        end else if (w_commit_cont) begin
            r_score <= choose_score;
        end else if (w_commit_won) begin
            r_score <= TARGET_SCORE;
        end else if (w_commit_lost) begin
            r_score <= 4'd0;
        end
    end

    assign score  = r_score;
    assign player = 1'b0;
`endif

    // Externally visible game status derived from the sequencer state
    always_comb begin
        w_game_state = GS_PLAYING;
        case (r_state)
            ST_WON:  w_game_state = GS_WON;
            ST_LOST: w_game_state = GS_LOST;
            default: w_game_state = GS_PLAYING;
        endcase
    end

    assign choose_pulse = (r_state == ST_ISSUE);
    assign rounds       = r_rounds;
    assign game_state   = w_game_state;

endmodule
`default_nettype wire

// File: tb/tb_dice_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dice_game_ctrl
//  Description : Self-checking bench for dice_game_ctrl. Two instances
//                (MAX_ROUNDS 15 and 2) share one stimulus stream; a
//                rule-level model predicts every output each cycle, and
//                hand-computed literals pin key points of the sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dice_game_ctrl;

`ifdef TWO_PLAYER_EN
    localparam bit TWO_PLAYER = 1'b1;
`else
    localparam bit TWO_PLAYER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic roll = 1'b0;
    logic choose_done = 1'b0;
    logic [1:0] choose_result = 2'd0;
    logic [3:0] choose_score = 4'd0;

    logic [1:0]      d_pulse;
    logic [1:0][2:0] d_roll_num;
    logic [1:0][3:0] d_score;
    logic [1:0]      d_player;
    logic [1:0][3:0] d_rounds;
    logic [1:0][1:0] d_gs;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    dice_game_ctrl #(.MAX_ROUNDS(15), .DICE_START(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .roll(roll), .choose_done(choose_done),
        .choose_result(choose_result), .choose_score(choose_score),
        .choose_pulse(d_pulse[0]), .roll_num(d_roll_num[0]), .score(d_score[0]),
        .player(d_player[0]), .rounds(d_rounds[0]), .game_state(d_gs[0])
    );

    dice_game_ctrl #(.MAX_ROUNDS(2), .DICE_START(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .roll(roll), .choose_done(choose_done),
        .choose_result(choose_result), .choose_score(choose_score),
        .choose_pulse(d_pulse[1]), .roll_num(d_roll_num[1]), .score(d_score[1]),
        .player(d_player[1]), .rounds(d_rounds[1]), .game_state(d_gs[1])
    );

    // ---------------- behavioural model ----------------
    localparam int P_READY = 0;   // waiting for a roll press
    localparam int P_SPIN  = 1;   // button held, die spinning
    localparam int P_PULSE = 2;   // request goes out to the choice stage
    localparam int P_AWAIT = 3;   // waiting for the choice stage answer
    localparam int P_OVER  = 4;   // game finished

    int m_phase [2];
    int m_die   [2];
    int m_player[2];
    int m_rounds[2];
    int m_gs    [2];
    int m_score [2][2];
    int m_max   [2] = '{15, 2};
    bit m_prev;
    bit m_rise;
    bit m_fall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = P_READY; m_die[i] = 1; m_player[i] = 0;
                m_rounds[i] = 0; m_gs[i] = 0; m_score[i][0] = 0; m_score[i][1] = 0;
            end
        end else begin
            m_rise = roll && !m_prev;
            m_fall = !roll && m_prev;
            for (int i = 0; i < 2; i++) begin
                case (m_phase[i])
                    P_READY: if (m_rise) m_phase[i] = P_SPIN;
                    P_SPIN: begin
                        if (m_fall) m_phase[i] = P_PULSE;
                        else m_die[i] = (m_die[i] == 6) ? 1 : m_die[i] + 1;
                    end
                    P_PULSE: m_phase[i] = P_AWAIT;
                    P_AWAIT: begin
                        if (choose_done) begin
                            if (choose_result == 2'd2) begin
                                m_score[i][m_player[i]] = 15; m_gs[i] = 2; m_phase[i] = P_OVER;
                            end else if (choose_result == 2'd1) begin
                                m_score[i][m_player[i]] = 0; m_gs[i] = 1; m_phase[i] = P_OVER;
                            end else begin
                                m_score[i][m_player[i]] = int'(choose_score);
                                m_rounds[i]++;
                                if (m_rounds[i] == m_max[i]) begin
                                    m_gs[i] = 1; m_phase[i] = P_OVER;
                                end else begin
                                    m_phase[i] = P_READY;
                                    if (TWO_PLAYER) m_player[i] = 1 - m_player[i];
                                end
                            end
                        end
                    end
                    default: begin
                        if (m_rise) begin
                            m_score[i][0] = 0; m_score[i][1] = 0; m_rounds[i] = 0;
                            m_player[i] = 0; m_gs[i] = 0; m_phase[i] = P_SPIN;
                        end
                    end
                endcase
            end
            m_prev = roll;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("pulse[%0d]", i),  int'(d_pulse[i]),    (m_phase[i] == P_PULSE) ? 1 : 0);
                check($sformatf("roll_num[%0d]", i), int'(d_roll_num[i]), m_die[i]);
                check($sformatf("score[%0d]", i),  int'(d_score[i]),    m_score[i][m_player[i]]);
                check($sformatf("player[%0d]", i), int'(d_player[i]),   m_player[i]);
                check($sformatf("rounds[%0d]", i), int'(d_rounds[i]),   m_rounds[i]);
                check($sformatf("game_state[%0d]", i), int'(d_gs[i]),   m_gs[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold roll for n spinning cycles, release; returns in the request cycle
    task automatic spin(input int n);
        roll = 1'b1;
        repeat (n + 1) tick();
        roll = 1'b0;
        tick();
    endtask

    task automatic respond(input logic [1:0] r, input logic [3:0] s);
        choose_done = 1'b1; choose_result = r; choose_score = s;
        tick();
        choose_done = 1'b0; choose_result = 2'd0; choose_score = 4'd0;
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "_pulse"},  int'(d_pulse[i]),    0);
            check({tag, "_roll"},   int'(d_roll_num[i]), 1);
            check({tag, "_score"},  int'(d_score[i]),    0);
            check({tag, "_player"}, int'(d_player[i]),   0);
            check({tag, "_rounds"}, int'(d_rounds[i]),   0);
            check({tag, "_gs"},     int'(d_gs[i]),       0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #0.5 cmp_on = 1'b1;
        check_reset_values("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

`ifndef TWO_PLAYER_EN
        // Four spinning cycles from 1 stop on 5; request one cycle after release
        spin(4);
        check("t1_pulse", int'(d_pulse[0]), 1);
        check("t1_roll0", int'(d_roll_num[0]), 5);
        check("t1_roll1", int'(d_roll_num[1]), 5);
        tick();
        check("t1_pulse_one_cycle", int'(d_pulse[0]), 0);

        respond(2'd0, 4'd5);
        check("t2_score", int'(d_score[0]), 5);
        check("t2_rounds", int'(d_rounds[0]), 1);
        check("t2_gs", int'(d_gs[1]), 0);

        // Second CONTINUE: the two-round instance is forced to lose
        spin(2); tick();
        check("t2_roll_wrap", int'(d_roll_num[0]), 1);
        respond(2'd0, 4'd9);
        check("t2_score9", int'(d_score[0]), 9);
        check("t2_rounds2", int'(d_rounds[0]), 2);
        check("t4_forced_lost", int'(d_gs[1]), 1);
        check("t4_rounds_sat", int'(d_rounds[1]), 2);

        // New press clears the finished game and spins on the same edge
        roll = 1'b1; tick();
        check("t4_clear_rounds", int'(d_rounds[1]), 0);
        check("t4_clear_score", int'(d_score[1]), 0);
        check("t4_clear_gs", int'(d_gs[1]), 0);
        check("t4_keep_score0", int'(d_score[0]), 9);
        tick(); roll = 1'b0; tick(); tick();
        respond(2'd2, 4'd3);
        check("t2_won_score", int'(d_score[0]), 15);
        check("t2_won_gs", int'(d_gs[0]), 2);

        // LOST zeroes the score whatever score comes with it
        spin(3); tick();
        respond(2'd0, 4'd7);
        check("t3_cont7", int'(d_score[0]), 7);
        spin(1); tick();
        respond(2'd1, 4'hF);
        check("t3_lostF_score", int'(d_score[0]), 0);
        check("t3_lostF_gs", int'(d_gs[0]), 1);
        spin(1); tick();
        respond(2'd1, 4'd0);
        check("t3_lost0_score", int'(d_score[0]), 0);
        check("t3_lost0_gs", int'(d_gs[0]), 1);

        // roll toggling while waiting is ignored
        spin(2); tick();
        roll = 1'b1; tick(); tick(); roll = 1'b0; tick();
        check("t5_wait_roll", int'(d_roll_num[0]), 3);
        check("t5_wait_gs", int'(d_gs[0]), 0);
        respond(2'd0, 4'd6);
        // spurious completion while idle is ignored
        choose_done = 1'b1; choose_result = 2'd2; choose_score = 4'hA;
        tick();
        choose_done = 1'b0; choose_result = 2'd0; choose_score = 4'd0;
        tick();
        check("t5_idle_score", int'(d_score[0]), 6);
        check("t5_idle_gs", int'(d_gs[0]), 0);
        check("t5_idle_rounds", int'(d_rounds[1]), 1);

        // Reset in the middle of a spin
        roll = 1'b1; tick(); tick(); tick();
        check("t5_spin_roll", int'(d_roll_num[0]), 5);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        roll = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
`else
        // Two-player alternation and score muxing
        spin(1); tick();
        respond(2'd0, 4'd3);
        check("t6_p1_active", int'(d_player[0]), 1);
        check("t6_p1_score", int'(d_score[0]), 0);
        spin(1); tick();
        respond(2'd0, 4'd4);
        check("t6_p0_active", int'(d_player[0]), 0);
        check("t6_p0_score", int'(d_score[0]), 3);
        check("t6_lost_player_held", int'(d_player[1]), 1);
        check("t6_lost_score", int'(d_score[1]), 4);
        check("t6_lost_gs", int'(d_gs[1]), 1);
        spin(1); tick();
        respond(2'd0, 4'd8);
        check("t6_p1_again", int'(d_player[0]), 1);
        check("t6_p1_score4", int'(d_score[0]), 4);
        check("t6_new_game_player", int'(d_player[1]), 1);
        check("t6_new_game_score", int'(d_score[1]), 0);
        check("t6_rounds", int'(d_rounds[0]), 3);
`endif

        tick(); tick();
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
